// File: rtl/result_display_sequencer_pkg.sv
// Shared types, constants and helpers for the result display sequencer:
// selection/state enums, the active-low 7-segment table and the
// double-dabble step used by the sequential binary-to-BCD converter.
package result_display_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_SUMA  = 3'd0,
    OP_RESTA = 3'd1,
    OP_MULT  = 3'd2,
    OP_DIV   = 3'd3,
    OP_POW   = 3'd4
  } op_idx_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  localparam int BIN_W      = 32;
  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Active-low segments {gfedcba}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One decimal digit to its segment pattern; non-decimal codes blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    if (nib < 4'd10) begin
      seg = SEG_DIGIT[nib];
    end else begin
      seg = SEG_BLANK;
    end
    return seg;
  endfunction

  // One double-dabble iteration: +3 on every nibble >= 5, then shift in bit_in.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  // Next selection, wrapping from the last result back to the first.
  function automatic op_idx_t next_op(input op_idx_t op);
    op_idx_t nxt;
    case (op)
      OP_SUMA:  nxt = OP_RESTA;
      OP_RESTA: nxt = OP_MULT;
      OP_MULT:  nxt = OP_DIV;
      OP_DIV:   nxt = OP_POW;
      OP_POW:   nxt = OP_SUMA;
      default:  nxt = OP_SUMA;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/result_display_sequencer_if.sv
// Result-word bus from the data memory (RAM[2..6]) to the display sequencer.
interface result_display_sequencer_if;
  logic [31:0] result_suma;
  logic [31:0] result_resta;
  logic [31:0] result_mult;
  logic [31:0] result_div;
  logic [31:0] result_pow;

  modport master (
    output result_suma, result_resta, result_mult, result_div, result_pow
  );

  modport slave (
    input result_suma, result_resta, result_mult, result_div, result_pow
  );
endinterface

// File: rtl/result_display_sequencer_bin2bcd.sv
// Sequential 32-bit binary to 10-digit BCD converter (double-dabble),
// one iteration per cycle. 'done' is high during the cycle whose clock
// edge performs the last iteration, so bcd is final right after it.
module bin2bcd_seq
  import result_display_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [BIN_W-1:0] mag,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r;
  logic [4:0]       cnt_r;
  logic             busy_r;
  logic             done_r;

  // Load on start, drop on abort, otherwise run 32 shift/add iterations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= '0;
      bcd_r  <= '0;
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      bin_r  <= mag;
      bcd_r  <= '0;
      cnt_r  <= 5'd0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (abort) begin
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (busy_r) begin
      bcd_r  <= dabble_step(bcd_r, bin_r[BIN_W-1]);
      bin_r  <= {bin_r[BIN_W-2:0], 1'b0};
      cnt_r  <= cnt_r + 5'd1;
      done_r <= (cnt_r == 5'd30);
      if (cnt_r == 5'd31) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: rtl/result_display_sequencer.sv
// Result display sequencer: debounced button selects one of five result
// words, which is continuously converted to decimal and shown on DIGITS
// active-low 7-segment displays with sign and overflow indicators.
module result_display_sequencer
  import result_display_sequencer_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SIGNED_DISP  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_next,
  result_display_sequencer_if.slave res_bus,
  output logic [DIGITS*7-1:0]       seg_n,
  output logic [2:0]                op_idx,
  output logic                      neg,
  output logic                      ovf,
  output logic                      busy
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // Debounce / selection state
  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] db_cnt_r;
  logic             step_r;
  op_idx_t          op_r;

  // Conversion state and registered display outputs
  conv_state_t          state_r;
  logic                 neg_snap_r;
  logic [DIGITS*7-1:0]  seg_r;
  logic                 neg_r;
  logic                 ovf_r;
  logic                 busy_r;

  // Combinational datapath
  logic [BIN_W-1:0]    sel_val_s;
  logic [BIN_W-1:0]    mag_s;
  logic                neg_in_s;
  logic                cvt_start_s;
  logic                cvt_abort_s;
  logic                cvt_busy_s;
  logic                cvt_done_s;
  logic [BCD_W-1:0]    bcd_s;
  logic                ovf_s;
  logic [DIGITS*7-1:0] seg_next_s;

  // Synchronise the raw button and accept a new level only after it has
  // differed from the accepted one for DEBOUNCE_CYC consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      db_cnt_r <= '0;
      step_r   <= 1'b0;
    end else begin
      sync1_r <= btn_next;
      sync2_r <= sync1_r;
      step_r  <= 1'b0;
      if (sync2_r != stable_r) begin
        if (db_cnt_r == DB_LAST) begin
          stable_r <= sync2_r;
          db_cnt_r <= '0;
          step_r   <= sync2_r;
        end else begin
          db_cnt_r <= db_cnt_r + CNT_W'(1'b1);
        end
      end else begin
        db_cnt_r <= '0;
      end
    end
  end

  // Advance the selection once per accepted press, wrapping after pow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= OP_SUMA;
    end else if (step_r) begin
      op_r <= next_op(op_r);
    end else begin
      op_r <= op_r;
    end
  end

  // Select the live result word and split it into magnitude and sign.
  always_comb begin
    case (op_r)
      OP_SUMA:  sel_val_s = res_bus.result_suma;
      OP_RESTA: sel_val_s = res_bus.result_resta;
      OP_MULT:  sel_val_s = res_bus.result_mult;
      OP_DIV:   sel_val_s = res_bus.result_div;
      OP_POW:   sel_val_s = res_bus.result_pow;
      default:  sel_val_s = res_bus.result_suma;
    endcase
    if ((SIGNED_DISP != 0) && sel_val_s[BIN_W-1]) begin
      mag_s    = ~sel_val_s + 32'd1;
      neg_in_s = 1'b1;
    end else begin
      mag_s    = sel_val_s;
      neg_in_s = 1'b0;
    end
  end

  // The converter snapshots the magnitude in LOAD; a selection step during
  // SHIFT throws the partial conversion away.
  assign cvt_start_s = (state_r == LOAD);
  assign cvt_abort_s = step_r && (state_r == SHIFT);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cvt_start_s),
    .abort (cvt_abort_s),
    .mag   (mag_s),
    .busy  (cvt_busy_s),
    .done  (cvt_done_s),
    .bcd   (bcd_s)
  );

  // Overflow detection on hidden digits and segment encoding of shown ones.
  always_comb begin
    ovf_s = 1'b0;
    for (int i = DIGITS; i < BCD_DIGITS; i++) begin
      ovf_s = ovf_s | (bcd_s[4*i +: 4] != 4'd0);
    end
    seg_next_s = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next_s[7*i +: 7] = ovf_s ? SEG_DASH : seg_encode(bcd_s[4*i +: 4]);
    end
  end

  // Free-running LOAD -> SHIFT -> COMMIT loop; display registers change only in COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= LOAD;
      neg_snap_r <= 1'b0;
      seg_r      <= '1;
      neg_r      <= 1'b0;
      ovf_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          neg_snap_r <= neg_in_s;
          if (step_r) begin
            // Selection changes this edge: reload with the new word.
            state_r <= LOAD;
            busy_r  <= 1'b0;
          end else begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        SHIFT: begin
          if (step_r) begin
            state_r <= LOAD;
            busy_r  <= 1'b0;
          end else if (cvt_done_s) begin
            state_r <= COMMIT;
            busy_r  <= 1'b1;
          end else if (!cvt_busy_s) begin
            // Converter idle without finishing: restart rather than stall.
            state_r <= LOAD;
            busy_r  <= 1'b0;
          end else begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        COMMIT: begin
          seg_r   <= seg_next_s;
          neg_r   <= neg_snap_r && (bcd_s != '0);
          ovf_r   <= ovf_s;
          state_r <= LOAD;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= LOAD;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign seg_n  = seg_r;
  assign op_idx = op_r;
  assign neg    = neg_r;
  assign ovf    = ovf_r;
  assign busy   = busy_r;

endmodule
